// File: rtl/rhythm_lane_engine.sv
// Note-lane engine: falling notes on a ramping shared tick, press judging, saturating score
// and registered per-lane pixel flags. Define RHYTHM_AUTOMISS_EN to flag notes that pass unhit.
//
// state  | meaning
// ARMED  | lane accepts press edges and judges them against the target window
// LOCKED | lane ignores presses after a miss until its note wraps to the top
module rhythm_lane_engine #(
   parameter int LANES        = 4,
   parameter int Y_W          = 11,
   parameter int STEP         = 5,
   parameter int NOTE_W       = 80,
   parameter int NOTE_H       = 50,
   parameter int X0           = 60,
   parameter int X_PITCH      = 160,
   parameter int TARGET_Y     = 350,
   parameter int WRAP_Y       = 510,
   parameter int WRAP_STAGGER = 20,
   parameter int PERIOD_W     = 32,
   parameter int PERIOD_INIT  = 2097152,
   parameter int PERIOD_MIN   = 524288,
   parameter int PERIOD_DEC   = 65536,
   parameter int RAMP_TICKS   = 256,
   parameter int SCORE_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [LANES-1:0]    btn,
   input  logic [Y_W-1:0]      hcount,
   input  logic [Y_W-1:0]      vcount,
   input  logic                blank,
   output logic [LANES-1:0]    pix_note,
   output logic [LANES-1:0]    pix_target,
   output logic [LANES-1:0]    hit,
   output logic [LANES-1:0]    miss,
   output logic                tick,
   output logic [PERIOD_W-1:0] period,
   output logic [SCORE_W-1:0]  score
);

   localparam int XW = Y_W + 1;
   localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
   localparam int CW = $clog2(LANES + 1);
   localparam int SW = SCORE_W + CW;
   localparam logic [PERIOD_W:0] DEC_FLOOR = (PERIOD_W+1)'(PERIOD_MIN) + (PERIOD_W+1)'(PERIOD_DEC);

   typedef enum logic {ARMED = 1'b0, LOCKED = 1'b1} lane_state_t;

   logic [PERIOD_W-1:0] cnt;
   logic [RW-1:0]       ramp_cnt;
   logic                tick_fire;
   logic [PERIOD_W-1:0] period_ramped;
   logic [LANES-1:0]    btn_rel;
   logic [LANES-1:0]    press, win_now, wrap, auto_miss, hit_nxt, miss_nxt, lane_x;
   logic [LANES-1:0]    pix_note_nxt, pix_target_nxt;
   logic [Y_W-1:0]      y_q   [LANES];
   logic [Y_W-1:0]      y_adv [LANES];
   logic [Y_W-1:0]      y_nxt [LANES];
   lane_state_t         state_q   [LANES];
   lane_state_t         state_nxt [LANES];
   logic [CW-1:0]       hit_cnt;
   logic [SW-1:0]       score_sum;

   function automatic logic in_win(input logic [Y_W-1:0] y);
      return (({1'b0, y} + XW'(NOTE_H)) >= XW'(TARGET_Y)) && ({1'b0, y} <= XW'(TARGET_Y + NOTE_H));
   endfunction

   // Compare against the widened floor so period-DEC can never wrap below zero.
   assign tick_fire     = (cnt == period - PERIOD_W'(1));
   assign period_ramped = ({1'b0, period} >= DEC_FLOOR) ? period - PERIOD_W'(PERIOD_DEC)
                                                        : PERIOD_W'(PERIOD_MIN);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         ramp_cnt <= '0;
         period   <= PERIOD_W'(PERIOD_INIT);
         tick     <= 1'b0;
      end else begin
         tick <= tick_fire;
         if (tick_fire) begin
            cnt <= '0;
            if (ramp_cnt == RW'(RAMP_TICKS - 1)) begin
               ramp_cnt <= '0;
               period   <= period_ramped;
            end else begin
               ramp_cnt <= ramp_cnt + RW'(1);
            end
         end else begin
            cnt <= cnt + PERIOD_W'(1);
         end
      end
   end

   // btn_rel marks "released last cycle"; clearing it in reset keeps a held button edge-free.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         press[i]   = btn[i] & btn_rel[i];
         wrap[i]    = ({1'b0, y_q[i]} >= XW'(WRAP_Y + i * WRAP_STAGGER));
         y_adv[i]   = wrap[i] ? '0 : y_q[i] + Y_W'(STEP);
         win_now[i] = in_win(y_q[i]);
      end
   end

   always_comb begin
      auto_miss = '0;
`ifdef RHYTHM_AUTOMISS_EN
      for (int i = 0; i < LANES; i++)
         auto_miss[i] = tick_fire & win_now[i] & ~in_win(y_adv[i]) & ~press[i];
`endif
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++)
         state_q[i] <= rst ? ARMED : state_nxt[i];
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         state_nxt[i] = state_q[i];
         case (state_q[i])
            ARMED:   if ((press[i] && !win_now[i]) || auto_miss[i]) state_nxt[i] = LOCKED;
            LOCKED:  if (tick_fire && wrap[i]) state_nxt[i] = ARMED;
            default: state_nxt[i] = ARMED;
         endcase
      end
   end

   always_comb begin
      hit_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         hit_nxt[i]  = (state_q[i] == ARMED) && press[i] && win_now[i];
         miss_nxt[i] = (state_q[i] == ARMED) && ((press[i] && !win_now[i]) || auto_miss[i]);
         if (hit_nxt[i])     y_nxt[i] = '0;
         else if (tick_fire) y_nxt[i] = y_adv[i];
         else                y_nxt[i] = y_q[i];
         hit_cnt = hit_cnt + CW'(hit_nxt[i]);
      end
      score_sum = SW'(score) + SW'(hit_cnt);
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         lane_x[i] = ({1'b0, hcount} >= XW'(X0 + i * X_PITCH))
                   && ({1'b0, hcount} <= XW'(X0 + i * X_PITCH + NOTE_W));
         pix_note_nxt[i] = ~blank & lane_x[i]
                         & ({1'b0, vcount} >= {1'b0, y_q[i]})
                         & ({1'b0, vcount} <= ({1'b0, y_q[i]} + XW'(NOTE_H)));
         pix_target_nxt[i] = ~blank & lane_x[i]
                           & ({1'b0, vcount} >= XW'(TARGET_Y))
                           & ({1'b0, vcount} <= XW'(TARGET_Y + NOTE_H));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++) y_q[i] <= '0;
         btn_rel    <= '0;
         hit        <= '0;
         miss       <= '0;
         score      <= '0;
         pix_note   <= '0;
         pix_target <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) y_q[i] <= y_nxt[i];
         btn_rel    <= ~btn;
         hit        <= hit_nxt;
         miss       <= miss_nxt;
         score      <= (score_sum > SW'({SCORE_W{1'b1}})) ? '1 : score_sum[SCORE_W-1:0];
         pix_note   <= pix_note_nxt;
         pix_target <= pix_target_nxt;
      end
   end

endmodule

// File: tb/tb_rhythm_lane_engine.sv
// Directed bench for rhythm_lane_engine with a fast tick (period 4 -> 3 -> 2) and a 2-bit score.
// Edge index e counts clock edges since the last reset release; tick n lands on e = 3,7,10,13, then 2n+7.
module tb_rhythm_lane_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  btn;
   logic [10:0] hcount, vcount;
   logic        blank;
   logic [3:0]  pix_note, pix_target, hit, miss;
   logic        tick;
   logic [31:0] period;
   logic [1:0]  score;

   int n_tests = 0;
   int n_fail  = 0;
   int ecnt    = -1;
   int n_m1    = 0;
   int n_m2    = 0;
   int n_h2    = 0;

`ifdef RHYTHM_AUTOMISS_EN
   localparam int EXP_AUTO = 1;
`else
   localparam int EXP_AUTO = 0;
`endif

   rhythm_lane_engine #(
      .LANES(4), .PERIOD_INIT(4), .PERIOD_MIN(2), .PERIOD_DEC(1), .RAMP_TICKS(2), .SCORE_W(2)
   ) dut (
      .clk(clk), .rst(rst), .btn(btn), .hcount(hcount), .vcount(vcount), .blank(blank),
      .pix_note(pix_note), .pix_target(pix_target), .hit(hit), .miss(miss),
      .tick(tick), .period(period), .score(score)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ecnt <= rst ? -1 : ecnt + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, ecnt);
      end
   endtask

   // Returns 1 ns after edge e has been taken.
   task automatic wait_edge(input int e);
      int guard;
      guard = 0;
      while (ecnt < e) begin
         @(posedge clk);
         #1;
         guard++;
         if (guard > 5000) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_edge: timeout at edge %0d waiting for %0d", ecnt, e);
            break;
         end
      end
   endtask

   initial begin
      rst = 1'b1; btn = '0; hcount = '0; vcount = '0; blank = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_hit", hit, 4'b0000);
      check_eq("rst_miss", miss, 4'b0000);
      check_eq("rst_tick", tick, 1'b0);
      check_eq("rst_pix_note", pix_note, 4'b0000);
      check_eq("rst_pix_target", pix_target, 4'b0000);
      check_eq("rst_period", period, 32'd4);
      check_eq("rst_score", score, 2'd0);
      rst = 1'b0;

      wait_edge(0);
      hcount = 11'd70; vcount = 11'd2;
      wait_edge(2);  check_eq("tick_e2", tick, 1'b0);
      wait_edge(3);  check_eq("tick_first", tick, 1'b1);
      wait_edge(4);  check_eq("tick_e4", tick, 1'b0);
      wait_edge(6);  check_eq("period_4", period, 32'd4);
      wait_edge(7);  check_eq("period_3", period, 32'd3);
      wait_edge(10); check_eq("tick_p3", tick, 1'b1);
      wait_edge(13); check_eq("period_2", period, 32'd2);
      wait_edge(15); check_eq("tick_p2", tick, 1'b1);
      wait_edge(16); check_eq("tick_p2_gap", tick, 1'b0);
      wait_edge(25); check_eq("period_floor", period, 32'd2);

      // lane 2 pressed at y=100: miss and lock
      wait_edge(45); btn = 4'b0100;
      wait_edge(46);
      check_eq("miss_lane2", miss, 4'b0100);
      check_eq("miss_lane2_nohit", hit, 4'b0000);
      btn = 4'b0000;

      // lane 0 at y=340: hit, held afterwards
      wait_edge(141); btn = 4'b0001;
      wait_edge(142);
      check_eq("hit_lane0", hit, 4'b0001);
      check_eq("score_1", score, 2'd1);
      check_eq("pix_pre_hit", pix_note, 4'b0000);
      wait_edge(143);
      check_eq("pix_y0_after_hit", pix_note, 4'b0001);
      check_eq("hold_no_hit", hit, 4'b0000);

      // y=350 on lanes 1..3: 1 and 3 hit, locked lane 2 ignored
      wait_edge(145); btn = 4'b1111;
      wait_edge(146);
      check_eq("hit_multi_locked", hit, 4'b1010);
      check_eq("miss_none_locked", miss, 4'b0000);
      check_eq("score_3", score, 2'd3);
      wait_edge(150);
      check_eq("hold_still_no_hit", hit, 4'b0000);
      btn = 4'b0000;

      // lane 2 wraps at tick 110, reaches y=350 at tick 180
      wait_edge(367); btn = 4'b0100;
      wait_edge(368);
      check_eq("hit_after_wrap", hit[2], 1'b1);
      check_eq("nomiss_after_wrap", miss[2], 1'b0);
      check_eq("score_sat_one", score, 2'd3);
      btn = 4'b0000;

      // mid-run reset on a tick edge with lane 3 held through it
      wait_edge(370); rst = 1'b1; btn = 4'b1000;
      @(posedge clk); #1;
      check_eq("mrst_tick", tick, 1'b0);
      check_eq("mrst_hit", hit, 4'b0000);
      check_eq("mrst_score", score, 2'd0);
      check_eq("mrst_period", period, 32'd4);
      check_eq("mrst_pix", pix_note, 4'b0000);
      rst = 1'b0;

      wait_edge(0);
      check_eq("held_no_miss_e0", miss, 4'b0000);
      check_eq("held_no_hit_e0", hit, 4'b0000);
      wait_edge(1);
      check_eq("held_no_miss_e1", miss, 4'b0000);
      btn = 4'b0000;

      wait_edge(4); hcount = 11'd220; vcount = 11'd350;
      wait_edge(5); check_eq("tgt_lane1", pix_target, 4'b0010);
      hcount = 11'd300; vcount = 11'd400;
      wait_edge(6); check_eq("tgt_corner", pix_target, 4'b0010);
      vcount = 11'd401;
      wait_edge(7); check_eq("tgt_below", pix_target, 4'b0000);
      check_eq("period_3_again", period, 32'd3);
      hcount = 11'd220; vcount = 11'd350; blank = 1'b1;
      wait_edge(8); check_eq("tgt_blank", pix_target, 4'b0000);
      blank = 1'b0; vcount = 11'd60;
      wait_edge(9); check_eq("note_bottom", pix_note, 4'b0010);
      vcount = 11'd61;
      wait_edge(10); check_eq("note_below", pix_note, 4'b0000);

      // all four at y=300 (window low edge): score 0+4 saturates to 3
      wait_edge(125); btn = 4'b1111;
      wait_edge(126);
      check_eq("hit_all", hit, 4'b1111);
      check_eq("score_sat_4", score, 2'd3);
      wait_edge(127); btn = 4'b0000;

      // y=400 hits; y=405 misses; lane 1 passes unpressed
      wait_edge(285); btn = 4'b0001;
      wait_edge(286);
      check_eq("hit_y400", hit, 4'b0001);
      check_eq("score_hold_sat", score, 2'd3);
      for (int e = 286; e <= 296; e++) begin
         wait_edge(e);
         if (e == 287) btn = 4'b0101;
         n_m1 += int'(miss[1]);
         n_m2 += int'(miss[2]);
         n_h2 += int'(hit[2]);
      end
      btn = 4'b0000;
      check_eq("automiss_lane1", n_m1, EXP_AUTO);
      check_eq("miss_y405_lane2", n_m2, 1);
      check_eq("nohit_y405_lane2", n_h2, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rhythm_lane_engine.md
# rhythm_lane_engine

- Parametrised note-lane engine for the rhythm-game VGA top.
- Owns per-lane falling-note positions on a shared tick whose period ramps down over time (speed-up).
- Judges debounced button presses against a fixed target zone and keeps a saturating score.
- Produces registered per-lane pixel flags for the colour mux, driven by the `vga_controller_640_60` counters.

## Interface

Parameters:
- `LANES`, 4: number of lanes/buttons
- `Y_W`, 11: width of coordinates and note positions
- `STEP`, 5: pixels a note advances per tick
- `NOTE_W`, 80 / `NOTE_H`, 50: note box size; box spans `x0..x0+NOTE_W`, `y..y+NOTE_H` inclusive
- `X0`, 60 / `X_PITCH`, 160: lane i left edge = `X0 + i*X_PITCH`
- `TARGET_Y`, 350: top of target box; target height = `NOTE_H`
- `WRAP_Y`, 510 / `WRAP_STAGGER`, 20: lane i wraps when `y >= WRAP_Y + i*WRAP_STAGGER`
- `PERIOD_W`, 32: tick period register width
- `PERIOD_INIT`, 2097152; `PERIOD_MIN`, 524288; `PERIOD_DEC`, 65536: clk cycles per tick (initial, floor, ramp decrement)
- `RAMP_TICKS`, 256: ticks between ramp steps
- `SCORE_W`, 16: score width

Ports:
- `clk` in 1: 100 MHz system clock
- `rst` in 1: synchronous, active-high reset
- `btn` in LANES: debounced buttons, 1 = pressed
- `hcount`, `vcount` in Y_W: pixel coordinates
- `blank` in 1: blanking
- `pix_note` out LANES: current pixel inside lane i note
- `pix_target` out LANES: current pixel inside lane i target
- `hit` out LANES: one-cycle pulse per judged hit
- `miss` out LANES: one-cycle pulse per judged miss
- `tick` out 1: one-cycle pulse on each position update
- `period` out PERIOD_W: current tick period
- `score` out SCORE_W: hit count, saturating

## Operation

- **Tick generator**
  - `cnt` counts `clk`. When `cnt == period-1`, `tick` pulses and `cnt` clears.
  - After every `RAMP_TICKS` ticks, `period` updates to `max(period-PERIOD_DEC, PERIOD_MIN)`.
  - The subtraction must not underflow.
- **Lane position**
  - On `tick`, if `y[i] >= WRAP_Y+i*WRAP_STAGGER` then `y[i] = 0`; otherwise `y[i] += STEP`.
- **Window**
  - `in_win[i] = (y[i]+NOTE_H >= TARGET_Y) && (y[i] <= TARGET_Y+NOTE_H)`.
  - Computed in Y_W+1 bits.
- **Per-lane FSM** with states ARMED and LOCKED:
  - ARMED, press edge (`btn` rising, edge-detect register inside the block), `in_win` true:
    - `hit[i]` pulses.
    - `y[i]` becomes 0 next cycle.
    - Lane stays ARMED.
  - ARMED, press edge, `in_win` false: `miss[i]` pulses and the lane goes to LOCKED.
  - LOCKED: press edges are ignored. The lane returns to ARMED on the tick that wraps `y[i]` to 0.
- **Score**
  - Score increases by popcount(`hit`) each cycle and saturates at all-ones.
- **Pixels**
  - `pix_note[i] = ~blank & hcount in lane i x-range & vcount in [y[i], y[i]+NOTE_H]`.
  - `pix_target[i]` uses the same x-range with y in `[TARGET_Y, TARGET_Y+NOTE_H]`.
  - Both are registered.

## Timing

- **Reset values:**
  - `cnt = 0`, `period = PERIOD_INIT`, all `y = 0`.
  - All lanes ARMED.
  - Edge registers = 0, so a button held through reset produces no edge.
  - `hit`, `miss`, `tick`, `pix_note`, `pix_target` = 0.
  - `score = 0`.
- **Mid-operation reset:** `rst` asserted at any point returns all of the above on the next edge. Pending pulses are dropped.
- **Latencies:**
  - `hit`/`miss` are asserted the cycle after the sampled press edge.
  - `score` updates in the same cycle `hit` is visible.
  - Pixel flags lag `hcount`/`vcount` by 1 cycle.
- **Press and tick in the same cycle:**
  - Judgement uses the pre-tick `y`.
  - A hit overrides the tick advance, so `y = 0`.
  - LOCKED-to-ARMED still follows the wrap rule.
- **Lane independence:** lanes judge independently. Simultaneous hits in several lanes all count in one cycle.
- **Ramp and tick in the same cycle:** the new `period` applies from the following count.

## Configuration

- Macro: `RHYTHM_AUTOMISS_EN`.
- **Defined:**
  - A lane in ARMED whose note leaves the window unhit (`in_win` goes 1 to 0 on a tick) pulses `miss[i]`.
  - The lane then goes to LOCKED until wrap.
- **Undefined:** only wrong-time presses generate `miss`. Notes passing unhit are silent.

## Test plan

- **Reset:** `PERIOD_INIT=4`, `rst` held 3 cycles, then released.
  - All outputs zero, `period=4`.
  - First `tick` 4 cycles after release.
- **Ramp:** `PERIOD_INIT=4`, `PERIOD_MIN=2`, `PERIOD_DEC=1`, `RAMP_TICKS=2`.
  - `period` steps 4 → 3 → 2 and holds at 2.
- **Hit:** advance lane 0 to `y=340` and press `btn[0]`.
  - `hit[0]` pulses once, `score=1`, `y[0]=0`.
  - Holding the button gives no further hits.
- **Miss and lock:** press `btn[2]` at `y=100`.
  - `miss[2]` pulses.
  - A press at `y=350` before wrap gives no `hit`.
  - After the wrap, a press at `y=350` hits.
- **Simultaneous hits:** `btn=4'b1111` with all notes in window and `score` preloaded to 65534.
  - `hit=4'b1111`, `score` saturates at 65535.
- **Automiss** (`RHYTHM_AUTOMISS_EN` defined): lane 1 passes `y=405` unpressed.
  - `miss[1]` pulses exactly once.
  - Without the macro, no pulse.
